// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath select codes and ALU operations.
package rv_ctrl_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef logic [3:0] state_t;
  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAdr   = 4'd2;
  localparam state_t StMemRead  = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWrite = 4'd5;
  localparam state_t StExecR    = 4'd6;
  localparam state_t StExecI    = 4'd7;
  localparam state_t StLui      = 4'd8;
  localparam state_t StAluWb    = 4'd9;
  localparam state_t StBrTgt    = 4'd10;
  localparam state_t StBranch   = 4'd11;
  localparam state_t StJTgt     = 4'd12;
  localparam state_t StJal      = 4'd13;
  localparam state_t StIllegal  = 4'd14;

  typedef logic [1:0] alu_op_t;
  localparam alu_op_t AluOpAdd   = 2'b00;
  localparam alu_op_t AluOpSub   = 2'b01;
  localparam alu_op_t AluOpFunct = 2'b10;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  function automatic logic [2:0] imm_src_decode(input logic [6:0] op);
    case (op)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      OpJal:    return ImmJ;
      OpLui:    return ImmU;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields onto an ALU control code.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_t    aluOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = AluAdd;
    case (aluOp)
      AluOpSub: aluControl = AluSub;
      AluOpFunct: begin
        case (funct3)
          // op5 separates R-type (sub possible) from I-type (addi never subtracts)
          3'b000:  aluControl = (op5 && funct7b5) ? AluSub : AluAdd;
          3'b010:  aluControl = AluSlt;
          3'b100:  aluControl = AluXor;
          3'b110:  aluControl = AluOr;
          3'b111:  aluControl = AluAnd;
          default: aluControl = AluAdd;
        endcase
      end
      default: aluControl = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences the shared datapath,
// stalls on the memory handshake and counts retired instructions.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic                 adrSrc,
  output logic                 regWrite,
  output logic [1:0]           resultSrc,
  output logic [1:0]           aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [2:0]           aluControl,
  output logic [2:0]           immSrc,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t                state_q, state_d;
  logic [INSTRET_W-1:0]  instret_q;
  alu_op_t               alu_op;
  logic                  retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    regWrite  = 1'b0;
    illegal   = 1'b0;
    resultSrc = ResAluOut;
    aluSrcA   = SrcAPc;
    aluSrcB   = SrcBRs2;
    alu_op    = AluOpAdd;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        aluSrcB   = SrcBFour;
        resultSrc = ResAluResult;
        irWrite   = mem_ready;
        pcWrite   = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBrTgt;
          OpJal:           state_d = StJTgt;
          OpLui:           state_d = StLui;
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        aluSrcA = SrcARs1;
        aluSrcB = SrcBImm;
        state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adrSrc  = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        resultSrc = ResReadData;
        regWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        memWrite = 1'b1;
        adrSrc   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        aluSrcA = SrcARs1;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StExecI: begin
        aluSrcA = SrcARs1;
        aluSrcB = SrcBImm;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StLui: begin
        aluSrcA = SrcAZero;
        aluSrcB = SrcBImm;
        state_d = StAluWb;
      end
      StAluWb: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StBrTgt: begin
        aluSrcA = SrcAOldPc;
        aluSrcB = SrcBImm;
        state_d = StBranch;
      end
      StBranch: begin
        aluSrcA = SrcARs1;
        alu_op  = AluOpSub;
        // funct3[0] inverts the sense: beq takes on zero, bne on non-zero
        pcWrite = zero ^ funct3[0];
        retire  = 1'b1;
        state_d = StFetch;
      end
      StJTgt: begin
        aluSrcA = SrcAOldPc;
        aluSrcB = SrcBImm;
        state_d = StJal;
      end
      StJal: begin
        aluSrcA = SrcAOldPc;
        aluSrcB = SrcBFour;
        pcWrite = 1'b1;
        state_d = StAluWb;
      end
      StIllegal: begin
        illegal = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
    if (!reset) begin
      mem_req  = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      regWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .aluOp     (alu_op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .op5       (op[5]),
    .aluControl(aluControl)
  );

  assign immSrc  = imm_src_decode(op);
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, reset/wrap corners and
// randomized instruction streams against an instruction-level reference model.
module tb_multicycle_control;

  localparam int unsigned W = 4;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic clk = 1'b0;
  logic reset, zero, mem_ready, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;
  logic mem_req, memWrite, irWrite, pcWrite, adrSrc, regWrite, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [2:0] aluControl, immSrc;
  logic [W-1:0] instret;

  logic [15:0] obs;
  logic [W-1:0] instret_m;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.INSTRET_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .memWrite  (memWrite),
    .irWrite   (irWrite),
    .pcWrite   (pcWrite),
    .adrSrc    (adrSrc),
    .regWrite  (regWrite),
    .resultSrc (resultSrc),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluControl(aluControl),
    .immSrc    (immSrc),
    .illegal   (illegal),
    .instret   (instret)
  );

  assign obs = {mem_req, memWrite, irWrite, pcWrite, adrSrc, regWrite,
                resultSrc, aluSrcA, aluSrcB, aluControl, illegal};

  function automatic logic [15:0] mk(input logic mq, input logic mw, input logic ir,
                                     input logic pw, input logic ad, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] al,
                                     input logic il);
    return {mq, mw, ir, pw, ad, rw, rs, a, b, al, il};
  endfunction

  function automatic logic [2:0] imm_ref(input logic [6:0] o);
    if (o == SW) return 3'd1;
    if (o == BR) return 3'd2;
    if (o == JAL) return 3'd3;
    if (o == LUI) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'd0:    return (o == RT && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive mem_ready, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic mr, input logic [15:0] e, input logic [2:0] imm_e,
                     input string nm);
    mem_ready = mr;
    @(negedge clk);
    check(nm, obs, e);
    check({nm, "_imm"}, 16'(immSrc), 16'(imm_e));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw,
                           input logic [2:0] imm_e, input logic [2:0] alu_e);
    logic [15:0] fwait, d0, wb;
    fwait = mk(1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0);
    d0    = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0);
    wb    = mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 0);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    check("instret", 16'(instret), 16'(instret_m));
    for (int i = 0; i < fw; i++) cyc(0, fwait, imm_e, "fetch_wait");
    cyc(1, mk(1, 0, 1, 1, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0), imm_e, "fetch");
    cyc(1'($urandom), d0, imm_e, "decode");
    if (o == LW || o == SW) begin
      cyc(1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0), imm_e, "memadr");
      for (int i = 0; i <= mw; i++) begin
        if (o == LW)
          cyc(i == mw, mk(1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0), imm_e, "memread");
        else
          cyc(i == mw, mk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0), imm_e, "memwrite");
      end
      if (o == LW)
        cyc(1'($urandom), mk(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 0), imm_e, "memwb");
      instret_m++;
    end else if (o == RT || o == IT || o == LUI) begin
      if (o == RT)
        cyc(1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, alu_e, 0), imm_e, "execr");
      else if (o == IT)
        cyc(1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, alu_e, 0), imm_e, "execi");
      else
        cyc(1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 3'd0, 0), imm_e, "lui");
      cyc(1'($urandom), wb, imm_e, "aluwb");
      instret_m++;
    end else if (o == BR) begin
      cyc(1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0), imm_e, "brtgt");
      cyc(1'($urandom), mk(0, 0, 0, z ^ f3[0], 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 0), imm_e,
          "branch");
      instret_m++;
    end else if (o == JAL) begin
      cyc(1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0), imm_e, "jtgt");
      cyc(1'($urandom), mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0), imm_e, "jal");
      cyc(1'($urandom), wb, imm_e, "jal_wb");
      instret_m++;
    end else begin
      cyc(1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 1), imm_e, "illegal");
    end
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         fw;
    int         mw;
    logic [2:0] imm;
    logic [2:0] alu;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] o;
    logic [6:0] legal[7];
    reset = 1'b0; mem_ready = 1'b0; op = LW; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    instret_m = '0;
    legal = '{LW, SW, RT, IT, BR, JAL, LUI};

    tbl[0]  = '{LW,  3'd2, 0, 0, 2, 2, 3'd0, 3'd0};
    tbl[1]  = '{RT,  3'd0, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[2]  = '{RT,  3'd0, 1, 0, 0, 0, 3'd0, 3'd1};
    tbl[3]  = '{BR,  3'd0, 0, 1, 0, 0, 3'd2, 3'd1};
    tbl[4]  = '{BR,  3'd1, 0, 1, 1, 0, 3'd2, 3'd1};
    tbl[5]  = '{JAL, 3'd0, 0, 0, 0, 0, 3'd3, 3'd0};
    tbl[6]  = '{BAD, 3'd0, 0, 0, 0, 0, 3'd0, 3'd0};
    tbl[7]  = '{SW,  3'd2, 0, 0, 1, 3, 3'd1, 3'd0};
    tbl[8]  = '{IT,  3'd2, 0, 0, 0, 0, 3'd0, 3'd5};
    tbl[9]  = '{IT,  3'd4, 1, 0, 0, 0, 3'd0, 3'd4};
    tbl[10] = '{IT,  3'd0, 1, 0, 0, 0, 3'd0, 3'd0};
    tbl[11] = '{RT,  3'd7, 0, 0, 0, 0, 3'd0, 3'd2};
    tbl[12] = '{RT,  3'd6, 0, 0, 0, 0, 3'd0, 3'd3};
    tbl[13] = '{RT,  3'd1, 1, 0, 0, 0, 3'd0, 3'd0};
    tbl[14] = '{LUI, 3'd0, 0, 0, 0, 0, 3'd4, 3'd0};

    #1;
    check("reset_outputs", obs, mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0));
    check("reset_instret", 16'(instret), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i])
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].fw, tbl[i].mw,
                tbl[i].imm, tbl[i].alu);

    // Reset while a store is stalled on memory: strobes must drop at once.
    op = SW; funct3 = 3'd2;
    cyc(1, mk(1, 0, 1, 1, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0), 3'd1, "rst_fetch");
    cyc(0, mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0), 3'd1, "rst_decode");
    cyc(0, mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0), 3'd1, "rst_memadr");
    mem_ready = 1'b0;
    #2;
    check("rst_pre", obs, mk(1, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
    reset = 1'b0;
    #1;
    check("rst_strobes", obs, mk(0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0));
    check("rst_instret", 16'(instret), 16'd0);
    instret_m = '0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, mk(1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0), 3'd1, "post_rst_fetch");

    // Counter wrap: all-ones then one more retired instruction.
    for (int i = 0; i < (1 << W) - 1; i++) run_instr(IT, 3'd0, 0, 0, 0, 0, 3'd0, 3'd0);
    check("instret_full", 16'(instret), 16'((1 << W) - 1));
    run_instr(LUI, 3'd0, 0, 0, 0, 0, 3'd4, 3'd0);
    check("instret_wrap", 16'(instret), 16'd0);

    for (int n = 0; n < 200; n++) begin
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal[$urandom_range(0, 6)];
      funct3 = 3'($urandom);
      funct7b5 = 1'($urandom);
      run_instr(o, funct3, funct7b5, 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2), imm_ref(o), alu_ref(o, funct3, funct7b5));
    end
    check("instret_final", 16'(instret), 16'(instret_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
